// File: rtl/nand_cpu_pkg.sv
// Shared CPU memory-system types: cache request codes, arbiter states, burst geometry.
// Block size and transfer size come from CACHE_BLOCK_SIZE / MEM_TRANS_SIZE.
`ifndef CACHE_BLOCK_SIZE
`define CACHE_BLOCK_SIZE 64
`endif
`ifndef MEM_TRANS_SIZE
`define MEM_TRANS_SIZE 16
`endif

package nand_cpu_pkg;
   typedef enum logic [1:0] {
      REQ_NONE  = 2'd0,
      REQ_READ  = 2'd1,
      REQ_WRITE = 2'd2
   } CacheRequest;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_REQUEST = 2'd1,
      ARB_BURST   = 2'd2
   } ArbState;

   localparam int MEM_BEATS  = `CACHE_BLOCK_SIZE / `MEM_TRANS_SIZE;
   localparam int MEM_ADDR_W = 16 - $clog2(`CACHE_BLOCK_SIZE);
   localparam int MEM_DATA_W = `MEM_TRANS_SIZE;
endpackage

// File: rtl/cache_request_ifc.sv
// Block request channel between a cache (master) and memory or an arbiter (slave).
interface cache_request_ifc
   import nand_cpu_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);
   CacheRequest       req;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] w_data;
   logic              ack;
   logic [DATA_W-1:0] r_data;

   modport master (output req, address, w_data, input ack, r_data);
   modport slave  (input req, address, w_data, output ack, r_data);
endinterface

// File: rtl/mem_arbiter_pick.sv
// Two-way winner select. ARB_ROUND_ROBIN_EN: ties go to the port not granted last;
// otherwise the d-cache has fixed priority.
module arb_pick (
   input  logic i_vld_i,
   input  logic i_vld_d,
   input  logic i_last_d,
   output logic o_grant_d
);
`ifdef ARB_ROUND_ROBIN_EN
   assign o_grant_d = (i_vld_i && i_vld_d) ? ~i_last_d : i_vld_d;
`else
   logic w_unused_pick;
   assign w_unused_pick = i_vld_i ^ i_last_d;
   assign o_grant_d     = i_vld_d;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between i-cache and d-cache; forwards request,
// ack and a BEATS-long data burst for the granted port. Policy: ARB_ROUND_ROBIN_EN.
module mem_arbiter
   import nand_cpu_pkg::*;
#(
   parameter int ADDR_W = 16 - $clog2(`CACHE_BLOCK_SIZE),
   parameter int BEATS  = `CACHE_BLOCK_SIZE / `MEM_TRANS_SIZE
) (
   input  logic             clk,
   input  logic             rst,
   cache_request_ifc.slave  i_cache,
   cache_request_ifc.slave  d_cache,
   cache_request_ifc.master mem,
   output logic             busy,
   output logic             grant_d
);
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   ArbState           r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_grant_d;

   logic              w_vld_i, w_vld_d, w_pick_d;
   CacheRequest       w_sel_req;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_abort, w_acked, w_last;

   assign w_vld_i    = (i_cache.req != REQ_NONE);
   assign w_vld_d    = (d_cache.req != REQ_NONE);
   assign w_sel_req  = r_grant_d ? d_cache.req : i_cache.req;
   assign w_sel_addr = r_grant_d ? d_cache.address : i_cache.address;
   assign w_abort    = (r_state == ARB_REQUEST) && (w_sel_req == REQ_NONE);
   assign w_acked    = (r_state == ARB_REQUEST) && !w_abort && mem.ack;
   assign w_last     = (r_cnt == CW'(BEATS - 1));

   // r_grant_d doubles as the last-grant history for round-robin
   arb_pick u_pick (
      .i_vld_i  (w_vld_i),
      .i_vld_d  (w_vld_d),
      .i_last_d (r_grant_d),
      .o_grant_d(w_pick_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ARB_IDLE;
         r_cnt     <= '0;
         r_grant_d <= 1'b0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_vld_i || w_vld_d) begin
                  r_grant_d <= w_pick_d;
                  r_state   <= ARB_REQUEST;
               end
            end
            ARB_REQUEST: begin
               if (w_abort) begin
                  r_state <= ARB_IDLE;
               end else if (mem.ack) begin
                  r_cnt   <= '0;
                  r_state <= ARB_BURST;
               end
            end
            ARB_BURST: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_last) r_state <= ARB_IDLE;
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      mem.req        = REQ_NONE;
      mem.address    = '0;
      mem.w_data     = '0;
      i_cache.ack    = w_acked & ~r_grant_d;
      d_cache.ack    = w_acked & r_grant_d;
      i_cache.r_data = '0;
      d_cache.r_data = '0;
      if (r_state == ARB_REQUEST) begin
         mem.req     = w_sel_req;
         mem.address = w_sel_addr;
      end
      if (r_state == ARB_BURST) begin
         mem.w_data = r_grant_d ? d_cache.w_data : i_cache.w_data;
         if (r_grant_d) d_cache.r_data = mem.r_data;
         else           i_cache.r_data = mem.r_data;
      end
   end

   assign busy    = (r_state != ARB_IDLE);
   assign grant_d = r_grant_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter (BEATS=4, ADDR_W=10); beat scoreboard in exp_q.
module tb_mem_arbiter;
   import nand_cpu_pkg::*;

   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, grant_d;
   int   checks = 0;
   int   failures = 0;
   logic [15:0] exp_q[$];

   cache_request_ifc #(.ADDR_W(10), .DATA_W(16)) ic();
   cache_request_ifc #(.ADDR_W(10), .DATA_W(16)) dc();
   cache_request_ifc #(.ADDR_W(10), .DATA_W(16)) mc();

   mem_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .i_cache(ic),
      .d_cache(dc),
      .mem    (mc),
      .busy   (busy),
      .grant_d(grant_d)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on one port: wait for grant, ack after dly cycles, 4 beats.
   task automatic serve(input bit is_d, input CacheRequest op, input logic [9:0] addr,
                        input int dly, input logic [15:0] base, input logic [15:0] step,
                        input int exp_wait);
      int waited;
      logic [15:0] exp, got, beat;
      if (is_d) begin dc.req = op; dc.address = addr; end
      else      begin ic.req = op; ic.address = addr; end
      #1;
      waited = 0;
      while (mc.req == REQ_NONE && waited < 20) begin
         tick();
         waited++;
      end
      checks++;
      if (waited != exp_wait) begin
         $display("FAIL grant_latency got=%0d exp=%0d", waited, exp_wait); failures++;
      end
      checks++;
      if (mc.req !== op) begin
         $display("FAIL mem_req got=%0d exp=%0d", mc.req, op); failures++;
         return;
      end
      checks++;
      if (mc.address !== addr) begin
         $display("FAIL mem_address got=%h exp=%h", mc.address, addr); failures++;
      end
      checks++;
      if (grant_d !== is_d || busy !== 1'b1) begin
         $display("FAIL grant got=%b/%b exp=%b/1", grant_d, busy, is_d); failures++;
      end
      repeat (dly) tick();
      checks++;
      if (ic.ack !== 1'b0 || dc.ack !== 1'b0) begin
         $display("FAIL early_ack got=%b%b exp=00", ic.ack, dc.ack); failures++;
      end
      mc.ack = 1'b1;
      #1;
      checks++;
      if ((is_d ? dc.ack : ic.ack) !== 1'b1 || (is_d ? ic.ack : dc.ack) !== 1'b0) begin
         $display("FAIL ack got=i%b d%b exp_d=%b", ic.ack, dc.ack, is_d); failures++;
      end
      tick();
      mc.ack = 1'b0;
      if (is_d) dc.req = REQ_NONE; else ic.req = REQ_NONE;
      for (int k = 0; k < NB; k++) begin
         beat = base + 16'(k) * step;
         if (op == REQ_READ) mc.r_data = beat;
         else if (is_d) dc.w_data = beat;
         else ic.w_data = beat;
         exp_q.push_back(beat);
         #1;
         exp = exp_q.pop_front();
         got = (op == REQ_READ) ? (is_d ? dc.r_data : ic.r_data) : mc.w_data;
         checks++;
         if (got !== exp) begin
            $display("FAIL beat%0d got=%h exp=%h", k, got, exp); failures++;
         end
         checks++;
         if ((is_d ? ic.r_data : dc.r_data) !== 16'h0 || busy !== 1'b1) begin
            $display("FAIL other_rdata got=%h busy=%b exp=0000/1",
                     is_d ? ic.r_data : dc.r_data, busy); failures++;
         end
         if (k < NB - 1) tick();
      end
      mc.r_data = '0; dc.w_data = '0; ic.w_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || grant_d !== 1'b0 || mc.req !== REQ_NONE || mc.address !== 10'h0 ||
          mc.w_data !== 16'h0 || ic.ack !== 1'b0 || dc.ack !== 1'b0 ||
          ic.r_data !== 16'h0 || dc.r_data !== 16'h0) begin
         $display("FAIL reset_state got=busy%b gd%b req%0d addr%h wd%h ack%b%b rd%h/%h exp=all0",
                  busy, grant_d, mc.req, mc.address, mc.w_data, ic.ack, dc.ack,
                  ic.r_data, dc.r_data); failures++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      serve(1'b1, REQ_READ, 10'h2A5, 2, 16'h1111, 16'h1111, 1);
      tick();
      checks++;
      if (busy !== 1'b0 || dc.r_data !== 16'h0) begin
         $display("FAIL read_end got=busy%b rd%h exp=0/0000", busy, dc.r_data); failures++;
      end
   endtask

   task automatic test_write_burst();
      tick();
      serve(1'b1, REQ_WRITE, 10'h133, 0, 16'h00A0, 16'h0001, 1);
      tick();
      checks++;
      if (mc.w_data !== 16'h0 || busy !== 1'b0) begin
         $display("FAIL write_end got=wd%h busy%b exp=0000/0", mc.w_data, busy); failures++;
      end
   endtask

`ifdef ARB_ROUND_ROBIN_EN
   task automatic test_round_robin();
      rst = 1'b1; tick(); rst = 1'b0;
      ic.req = REQ_READ; ic.address = 10'h011;
      serve(1'b1, REQ_READ, 10'h022, 1, 16'h0100, 16'h1, 1);
      dc.req = REQ_READ;
      serve(1'b0, REQ_READ, 10'h011, 1, 16'h0200, 16'h1, 2);
      ic.req = REQ_READ;
      serve(1'b1, REQ_READ, 10'h022, 1, 16'h0300, 16'h1, 2);
      serve(1'b0, REQ_READ, 10'h011, 1, 16'h0400, 16'h1, 2);
      tick();
   endtask
`else
   task automatic test_fixed_priority();
      tick();
      ic.req = REQ_READ; ic.address = 10'h011;
      serve(1'b1, REQ_READ, 10'h022, 1, 16'h0100, 16'h1, 1);
      dc.req = REQ_READ;
      serve(1'b1, REQ_READ, 10'h023, 0, 16'h0200, 16'h1, 2);
      serve(1'b0, REQ_READ, 10'h011, 1, 16'h0300, 16'h1, 2);
      tick();
   endtask
`endif

   task automatic test_reset_mid_burst();
      tick();
      dc.req = REQ_READ; dc.address = 10'h0F0;
      tick();
      mc.ack = 1'b1;
      tick();
      mc.ack = 1'b0; dc.req = REQ_NONE;
      mc.r_data = 16'hBEE0;
      tick();
      mc.r_data = 16'hBEE1;
      tick();
      mc.r_data = 16'hBEE2;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || grant_d !== 1'b0 || dc.r_data !== 16'h0 || mc.req !== REQ_NONE ||
          mc.w_data !== 16'h0 || dc.ack !== 1'b0) begin
         $display("FAIL mid_burst_reset got=busy%b gd%b rd%h req%0d exp=0/0/0000/0",
                  busy, grant_d, dc.r_data, mc.req); failures++;
      end
      mc.r_data = '0;
      serve(1'b0, REQ_READ, 10'h055, 1, 16'h7000, 16'h1, 1);
      tick();
   endtask

   task automatic test_abort();
      tick();
      dc.req = REQ_READ; dc.address = 10'h3C3;
      tick();
      ic.req = REQ_READ; ic.address = 10'h0AA;
      tick();
      dc.req = REQ_NONE;
      #1;
      checks++;
      if (dc.ack !== 1'b0 || mc.req !== REQ_NONE) begin
         $display("FAIL abort_cycle got=ack%b req%0d exp=0/0", dc.ack, mc.req); failures++;
      end
      tick();
      checks++;
      if (busy !== 1'b0 || dc.ack !== 1'b0) begin
         $display("FAIL abort_idle got=busy%b ack%b exp=0/0", busy, dc.ack); failures++;
      end
      serve(1'b0, REQ_READ, 10'h0AA, 0, 16'h5000, 16'h1, 1);
      tick();
   endtask

   initial begin
      ic.req = REQ_NONE; ic.address = '0; ic.w_data = '0;
      dc.req = REQ_NONE; dc.address = '0; dc.w_data = '0;
      mc.ack = 1'b0; mc.r_data = '0;
      test_reset();
      test_single_read();
      test_write_burst();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
`else
      test_fixed_priority();
`endif
      test_reset_mid_burst();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
